// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard: tracks pending writes per register and stalls hazarding lanes.
// Optional feature: define SCOREBOARD_BYPASS_EN to let sufficiently aged pending sources issue via forwarding.
module issue_scoreboard (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        issue_valid0_i,
    input  logic        issue_valid1_i,
    input  logic [4:0]  rs1_addr0_i,
    input  logic [4:0]  rs2_addr0_i,
    input  logic [4:0]  rd_addr0_i,
    input  logic        rd_write0_i,
    input  logic        is_load0_i,
    input  logic [4:0]  rs1_addr1_i,
    input  logic [4:0]  rs2_addr1_i,
    input  logic [4:0]  rd_addr1_i,
    input  logic        rd_write1_i,
    input  logic        is_load1_i,
    input  logic        pipe_stall_i,
    input  logic [4:0]  rd_addr0_wb_i,
    input  logic        rd_write0_wb_i,
    input  logic [4:0]  rd_addr1_wb_i,
    input  logic        rd_write1_wb_i,
    output logic        stall0_o,
    output logic        stall1_o,
    output logic [31:0] pending_o,
    output logic        busy_o
);

    logic [31:0]       r_pending;
    logic [31:0]       r_load;
    logic [31:0][1:0]  r_age;

    logic [31:0] w_ready;
    logic [31:0] w_set;
    logic [31:0] w_set_load;
    logic [31:0] w_clr;
    logic        w_src_haz0;
    logic        w_src_haz1;
    logic        w_waw0;
    logic        w_waw1;
    logic        w_intra;
    logic        w_stall0;
    logic        w_stall1;
    logic        w_fire0;
    logic        w_fire1;

    function automatic logic f_src_hazard(input logic [4:0]  idx,
                                          input logic [31:0] pend,
                                          input logic [31:0] rdy);
        return (idx != 5'd0) && pend[idx] && !rdy[idx];
    endfunction

    function automatic logic f_waw(input logic        wr,
                                   input logic [4:0]  rd,
                                   input logic [31:0] pend);
        return wr && (rd != 5'd0) && pend[rd];
    endfunction

    // A pending source is forwardable once its producer has advanced far enough down the pipe.
    always_comb begin
        w_ready = '0;
`ifdef SCOREBOARD_BYPASS_EN
        for (int r = 0; r < 32; r++) begin
            w_ready[r] = r_load[r] ? (r_age[r] >= 2'd2) : (r_age[r] >= 2'd1);
        end
`endif
    end

    assign w_src_haz0 = f_src_hazard(rs1_addr0_i, r_pending, w_ready)
                      | f_src_hazard(rs2_addr0_i, r_pending, w_ready);
    assign w_src_haz1 = f_src_hazard(rs1_addr1_i, r_pending, w_ready)
                      | f_src_hazard(rs2_addr1_i, r_pending, w_ready);
    assign w_waw0     = f_waw(rd_write0_i, rd_addr0_i, r_pending);
    assign w_waw1     = f_waw(rd_write1_i, rd_addr1_i, r_pending);

    // Lane 1 may not consume or overwrite lane 0's destination within the same bundle.
    assign w_intra = rd_write0_i && (rd_addr0_i != 5'd0) &&
                     ((rd_addr0_i == rs1_addr1_i) || (rd_addr0_i == rs2_addr1_i) ||
                      (rd_write1_i && (rd_addr0_i == rd_addr1_i)));

    assign w_stall0 = issue_valid0_i & (pipe_stall_i | w_src_haz0 | w_waw0);
    assign w_stall1 = issue_valid1_i & (pipe_stall_i | ~issue_valid0_i | w_stall0 |
                                        w_src_haz1 | w_waw1 | w_intra);
    assign w_fire0  = issue_valid0_i & ~w_stall0;
    assign w_fire1  = issue_valid1_i & ~w_stall1;

    always_comb begin
        w_set      = '0;
        w_set_load = '0;
        w_clr      = '0;
        if (w_fire0 && rd_write0_i && (rd_addr0_i != 5'd0)) begin
            w_set[rd_addr0_i]      = 1'b1;
            w_set_load[rd_addr0_i] = is_load0_i;
        end
        if (w_fire1 && rd_write1_i && (rd_addr1_i != 5'd0)) begin
            w_set[rd_addr1_i]      = 1'b1;
            w_set_load[rd_addr1_i] = is_load1_i;
        end
        if (rd_write0_wb_i && (rd_addr0_wb_i != 5'd0)) begin
            w_clr[rd_addr0_wb_i] = 1'b1;
        end
        if (rd_write1_wb_i && (rd_addr1_wb_i != 5'd0)) begin
            w_clr[rd_addr1_wb_i] = 1'b1;
        end
    end

    // Register 0 is never touched after reset, so it can never be pending.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pending <= '0;
            r_load    <= '0;
            r_age     <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                r_load[r] <= w_set[r] ? w_set_load[r] : r_load[r];
                if (w_set[r]) begin
                    r_pending[r] <= 1'b1;
                    r_age[r]     <= 2'd0;
                end else if (w_clr[r]) begin
                    r_pending[r] <= 1'b0;
                    r_age[r]     <= 2'd0;
                end else if (r_pending[r] && !pipe_stall_i && (r_age[r] != 2'd3)) begin
                    r_age[r] <= r_age[r] + 2'd1;
                end
            end
        end
    end

    assign stall0_o  = w_stall0;
    assign stall1_o  = w_stall1;
    assign pending_o = r_pending;
    assign busy_o    = |r_pending;

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 clock_i  in  1  core clock; all state updates on rising edge.
REQ-002 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-003 issue_valid0_i / issue_valid1_i  in  1 each  lane 0 (older) / lane 1 (younger) holds an instruction at issue.
REQ-004 rs1_addr0_i, rs2_addr0_i, rd_addr0_i  in  5 each  lane-0 source and destination register indices.
REQ-005 rd_write0_i  in  1  lane 0 writes rd; is_load0_i  in  1  lane-0 result comes from the LSU.
REQ-006 rs1_addr1_i, rs2_addr1_i, rd_addr1_i, rd_write1_i, is_load1_i  in  5/5/5/1/1  lane-1 equivalents.
REQ-007 pipe_stall_i  in  1  downstream stall; no issue, ages frozen.
REQ-008 rd_addr0_wb_i, rd_write0_wb_i, rd_addr1_wb_i, rd_write1_wb_i  in  5/1/5/1  writeback ports 0/1.
REQ-009 stall0_o / stall1_o  out  1 each  lane must not issue this cycle (combinational).
REQ-010 pending_o  out  32  per-register pending-write bits; busy_o  out  1  OR of pending_o.

Function
REQ-011 State per register r: pending[r], load[r], age[r] (2 bits, saturating at 3); register 0 is never pending.
REQ-012 Source hazard on lane L: source index nonzero, pending[src]=1, and not bypass-ready (REQ-024/025).
REQ-013 WAW hazard on lane L: rd_write=1, rd nonzero, pending[rd]=1.
REQ-014 stall0_o = issue_valid0_i & (pipe_stall_i | lane-0 source hazard | lane-0 WAW hazard).
REQ-015 stall1_o = issue_valid1_i & (pipe_stall_i | ~issue_valid0_i | stall0_o | lane-1 source or WAW hazard | intra-bundle hazard).
REQ-016 Intra-bundle hazard: rd_write0_i, rd_addr0_i nonzero, and rd_addr0_i equals rs1_addr1_i, rs2_addr1_i, or (with rd_write1_i) rd_addr1_i.
REQ-017 Lane fires when issue_valid=1 and stall=0; a firing write (rd nonzero) sets pending[rd]=1, load[rd]=is_load, age[rd]=0 on the next edge.
REQ-018 Writeback port with write=1 and addr nonzero clears pending[addr] next edge; both ports on same addr clear it once.
REQ-019 Same-cycle set and clear of one register: set wins.
REQ-020 Each cycle pipe_stall_i=0, every pending entry not set this cycle increments age, saturating at 3; pipe_stall_i=1 holds all ages.
REQ-021 Outputs reflect state only; no combinational path from writeback ports to stall0_o/stall1_o (clear visible next cycle).
REQ-022 Issue-to-stall decision latency 0 cycles; set/clear take effect 1 cycle after the edge.

Reset
REQ-023 reset_n_i low: all pending, load, age cleared immediately; pending_o=0, busy_o=0, stall outputs purely input-driven; mid-operation reset discards all tracked writes.

Configuration
REQ-024 Macro SCOREBOARD_BYPASS_EN defined: pending source is bypass-ready when load=0 and age>=1, or load=1 and age>=2; these do not stall.
REQ-025 SCOREBOARD_BYPASS_EN undefined: no source is bypass-ready; any pending source stalls until writeback clears it.

Verification
REQ-026 Reset, lane 0 fires rd=5 ALU; next cycle lane 0 rs1=5 -> stall0_o=1; with BYPASS_EN one cycle later stall0_o=0, without it stall0_o=1 until wb clears x5.
REQ-027 Bundle lane0 rd=3, lane1 rs2=3 -> stall0_o=0, stall1_o=1; pending_o[3]=1 next cycle.
REQ-028 Load rd=7, BYPASS_EN, pipe_stall_i held 2 cycles then released -> rs1=7 stalls until age reaches 2 (2 unstalled cycles).
REQ-029 Wb ports both rd=9 while lane0 fires rd=9 not previously pending -> pending_o[9]=1 after edge.
REQ-030 Lane fires rd=0 and reads x0 -> pending_o stays 0, no stalls; then assert reset_n_i with 4 entries pending -> pending_o=0, busy_o=0 without clock edge.
